// File: rtl/dual_issue_scoreboard.sv
// Dual-issue scheduler: RAW/WAW hazard checks against a 32-entry busy
// scoreboard and between the two lanes, plus fixed-latency write-back
// delay lines that drive both register-file write ports.
module dual_issue_scoreboard #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid1,
  input  logic [4:0]       rs1_addr1,
  input  logic [4:0]       rs2_addr1,
  input  logic [4:0]       rd_addr1,
  input  logic             wen1,
  input  logic             valid2,
  input  logic [4:0]       rs1_addr2,
  input  logic [4:0]       rs2_addr2,
  input  logic [4:0]       rd_addr2,
  input  logic             wen2,
  output logic             issue1,
  output logic             issue2,
  output logic             wb_wen1,
  output logic             wb_wen2,
  output logic [4:0]       wb_rd1,
  output logic [4:0]       wb_rd2,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned PW   = LAT * AW;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LAT-1:0]   p1_wen_q, p1_wen_d, p2_wen_q, p2_wen_d;
  logic [PW-1:0]    p1_rd_q, p1_rd_d, p2_rd_q, p2_rd_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic wr1, wr2, intra, iss1, iss2, ent1, ent2;
  logic [NREG-1:0] set_v, clr_v;

  // Hazard detection and issue decision (registered busy only, no bypass)
  always_comb begin
    wr1   = wen1 && (rd_addr1 != '0);
    wr2   = wen2 && (rd_addr2 != '0);
    intra = wr1 && ((rs1_addr2 == rd_addr1) || (rs2_addr2 == rd_addr1) ||
                    (wr2 && (rd_addr2 == rd_addr1)));
    iss1  = valid1 && !busy_q[rs1_addr1] && !busy_q[rs2_addr1] &&
            !(wr1 && busy_q[rd_addr1]);
    iss2  = iss1 && valid2 && !busy_q[rs1_addr2] && !busy_q[rs2_addr2] &&
            !(wr2 && busy_q[rd_addr2]) && !intra;
    ent1  = iss1 && wr1;
    ent2  = iss2 && wr2;
  end

  // Next state: delay-line shift, scoreboard set/clear, stall counter
  always_comb begin
    p1_wen_d = LAT'({p1_wen_q, ent1});
    p2_wen_d = LAT'({p2_wen_q, ent2});
    p1_rd_d  = PW'({p1_rd_q, (ent1 ? rd_addr1 : AW'(0))});
    p2_rd_d  = PW'({p2_rd_q, (ent2 ? rd_addr2 : AW'(0))});

    set_v = '0;
    clr_v = '0;
    if (wb_wen1) clr_v[wb_rd1] = 1'b1;
    if (wb_wen2) clr_v[wb_rd2] = 1'b1;
    if (ent1)    set_v[rd_addr1] = 1'b1;
    if (ent2)    set_v[rd_addr2] = 1'b1;
    // Set wins over clear on the same edge; x0 is never tracked
    busy_d    = (busy_q & ~clr_v) | set_v;
    busy_d[0] = 1'b0;

    stall_d = stall_q;
    if (valid1 && !iss1 && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  // State registers with synchronous reset discarding in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      p1_wen_q <= '0;
      p2_wen_q <= '0;
      p1_rd_q  <= '0;
      p2_rd_q  <= '0;
      stall_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      p1_wen_q <= p1_wen_d;
      p2_wen_q <= p2_wen_d;
      p1_rd_q  <= p1_rd_d;
      p2_rd_q  <= p2_rd_d;
      stall_q  <= stall_d;
    end
  end

  // Last delay-line stage is the registered write-back port
  assign issue1    = iss1;
  assign issue2    = iss2;
  assign wb_wen1   = p1_wen_q[LAT-1];
  assign wb_wen2   = p2_wen_q[LAT-1];
  assign wb_rd1    = p1_rd_q[PW-1 -: AW];
  assign wb_rd2    = p2_rd_q[PW-1 -: AW];
  assign busy      = busy_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard (LAT=3); a second CNT_W=4
// instance shares the stimulus to check counter saturation.
module tb_dual_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid1, wen1, valid2, wen2;
  logic [4:0]  rs1_addr1, rs2_addr1, rd_addr1;
  logic [4:0]  rs1_addr2, rs2_addr2, rd_addr2;
  logic        issue1, issue2, wb_wen1, wb_wen2;
  logic [4:0]  wb_rd1, wb_rd2;
  logic [31:0] busy;
  logic [15:0] stall_cnt;
  logic        s_issue1, s_issue2, s_wb_wen1, s_wb_wen2;
  logic [4:0]  s_wb_rd1, s_wb_rd2;
  logic [31:0] s_busy;
  logic [3:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_issue_scoreboard #(.LAT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .valid1(valid1), .rs1_addr1(rs1_addr1), .rs2_addr1(rs2_addr1),
    .rd_addr1(rd_addr1), .wen1(wen1),
    .valid2(valid2), .rs1_addr2(rs1_addr2), .rs2_addr2(rs2_addr2),
    .rd_addr2(rd_addr2), .wen2(wen2),
    .issue1(issue1), .issue2(issue2),
    .wb_wen1(wb_wen1), .wb_wen2(wb_wen2), .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  dual_issue_scoreboard #(.LAT(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .valid1(valid1), .rs1_addr1(rs1_addr1), .rs2_addr1(rs2_addr1),
    .rd_addr1(rd_addr1), .wen1(wen1),
    .valid2(valid2), .rs1_addr2(rs1_addr2), .rs2_addr2(rs2_addr2),
    .rd_addr2(rd_addr2), .wen2(wen2),
    .issue1(s_issue1), .issue2(s_issue2),
    .wb_wen1(s_wb_wen1), .wb_wen2(s_wb_wen2), .wb_rd1(s_wb_rd1), .wb_rd2(s_wb_rd2),
    .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid1 = 0; wen1 = 0; rs1_addr1 = 0; rs2_addr1 = 0; rd_addr1 = 0;
    valid2 = 0; wen2 = 0; rs1_addr2 = 0; rs2_addr2 = 0; rd_addr2 = 0;
  endtask

  task automatic lane1(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w);
    valid1 = 1; rs1_addr1 = a; rs2_addr1 = b; rd_addr1 = d; wen1 = w;
  endtask

  task automatic lane2(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w);
    valid2 = 1; rs1_addr2 = a; rs2_addr2 = b; rd_addr2 = d; wen2 = w;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if ({wb_wen1, wb_wen2} !== 2'b00) begin bad++; $display("FAIL reset_wen got=%b exp=00", {wb_wen1, wb_wen2}); end
    total++; if ({wb_rd1, wb_rd2} !== 10'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", {wb_rd1, wb_rd2}); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    total++; if ({issue1, issue2} !== 2'b00) begin bad++; $display("FAIL reset_issue got=%b exp=00", {issue1, issue2}); end
  endtask

  task automatic test_independent();
    do_reset();
    lane1(5'd1, 5'd2, 5'd5, 1'b1);
    lane2(5'd3, 5'd4, 5'd6, 1'b1);
    #1;
    total++; if ({issue1, issue2} !== 2'b11) begin bad++; $display("FAIL indep_issue got=%b exp=11", {issue1, issue2}); end
    tick(); idle(); #1;
    total++; if (busy !== 32'h0000_0060) begin bad++; $display("FAIL indep_busy_set got=%h exp=00000060", busy); end
    tick();
    total++; if ({wb_wen1, wb_wen2} !== 2'b00) begin bad++; $display("FAIL indep_wen_early got=%b exp=00", {wb_wen1, wb_wen2}); end
    tick();
    total++; if ({wb_wen1, wb_wen2} !== 2'b11) begin bad++; $display("FAIL indep_wen got=%b exp=11", {wb_wen1, wb_wen2}); end
    total++; if ({wb_rd1, wb_rd2} !== {5'd5, 5'd6}) begin bad++; $display("FAIL indep_rd got=%0d/%0d exp=5/6", wb_rd1, wb_rd2); end
    total++; if (busy !== 32'h0000_0060) begin bad++; $display("FAIL indep_busy_hold got=%h exp=00000060", busy); end
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL indep_busy_clr got=%h exp=0", busy); end
    total++; if ({wb_wen1, wb_wen2} !== 2'b00) begin bad++; $display("FAIL indep_wen_pulse got=%b exp=00", {wb_wen1, wb_wen2}); end
  endtask

  task automatic test_intra_raw();
    do_reset();
    lane1(5'd1, 5'd2, 5'd7, 1'b1);
    lane2(5'd7, 5'd3, 5'd8, 1'b1);
    #1;
    total++; if ({issue1, issue2} !== 2'b10) begin bad++; $display("FAIL raw_pair got=%b exp=10", {issue1, issue2}); end
    tick(); idle();
    lane1(5'd7, 5'd3, 5'd8, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (issue1 !== 1'b0) begin bad++; $display("FAIL raw_stall_c%0d got=%b exp=0", c, issue1); end
      tick();
    end
    #1;
    total++; if (issue1 !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", issue1); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_stall_cnt got=%0d exp=3", stall_cnt); end
    tick(); idle(); #1;
    total++; if (busy !== 32'h0000_0100) begin bad++; $display("FAIL raw_busy8 got=%h exp=00000100", busy); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_stall_hold got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_waw();
    do_reset();
    lane1(5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    total++; if (issue1 !== 1'b1) begin bad++; $display("FAIL waw_first got=%b exp=1", issue1); end
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (issue1 !== 1'b0) begin bad++; $display("FAIL waw_stall_c%0d got=%b exp=0", c, issue1); end
      if (c == 3) begin
        total++; if (wb_wen1 !== 1'b1 || wb_rd1 !== 5'd9) begin bad++; $display("FAIL waw_wb got=%b/%0d exp=1/9", wb_wen1, wb_rd1); end
      end
      tick();
    end
    #1;
    total++; if (issue1 !== 1'b1) begin bad++; $display("FAIL waw_release got=%b exp=1", issue1); end
    tick(); idle();
  endtask

  task automatic test_x0();
    do_reset();
    lane1(5'd1, 5'd2, 5'd0, 1'b1);
    lane2(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    total++; if ({issue1, issue2} !== 2'b11) begin bad++; $display("FAIL x0_issue got=%b exp=11", {issue1, issue2}); end
    tick(); idle();
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++; if (busy !== 32'h0 || {wb_wen1, wb_wen2} !== 2'b00) begin
        bad++; $display("FAIL x0_quiet_c%0d busy=%h wen=%b exp=0/00", c, busy, {wb_wen1, wb_wen2});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lane1(5'd1, 5'd2, 5'd12, 1'b1);
    lane2(5'd3, 5'd4, 5'd13, 1'b1);
    tick(); idle(); #1;
    total++; if (busy !== 32'h0000_3000) begin bad++; $display("FAIL mid_busy got=%h exp=00003000", busy); end
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (busy !== 32'h0 || {wb_wen1, wb_wen2} !== 2'b00) begin
        bad++; $display("FAIL mid_flush_c%0d busy=%h wen=%b exp=0/00", c, busy, {wb_wen1, wb_wen2});
      end
      tick();
    end
  endtask

  // Self-dependent write x20 <- x20 re-presented continuously: issues every 4th cycle
  task automatic test_back_to_back_sat();
    logic exp_iss;
    do_reset();
    lane1(5'd20, 5'd0, 5'd20, 1'b1);
    for (int c = 0; c < 28; c++) begin
      #1;
      exp_iss = ((c % 4) == 0);
      total++; if (issue1 !== exp_iss) begin bad++; $display("FAIL b2b_issue_c%0d got=%b exp=%b", c, issue1, exp_iss); end
      if (c == 24) begin
        total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_mid got=%0d exp=15", s_stall_cnt); end
      end
      tick();
    end
    idle();
    tick(); #1;
    total++; if (stall_cnt !== 16'd21) begin bad++; $display("FAIL b2b_stall_cnt got=%0d exp=21", stall_cnt); end
    total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", s_stall_cnt); end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_independent();
    test_intra_raw();
    test_waw();
    test_x0();
    test_reset_mid();
    test_back_to_back_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_scoreboard.md
Name: dual_issue_scoreboard

Overview:
- Issue scheduler for the 2-way superscalar core.
- Decides each cycle whether lane 1 (older) and lane 2 (younger) may issue, based on RAW/WAW hazards against a 32-entry busy scoreboard and against each other.
- Generates the delayed write-enables and destination addresses that drive the two register-file write ports after a fixed execution latency.
- Sits between decode and the register file/ALU pair.

Parameters:
- LAT, 3, execution latency in cycles from issue to register-file write (legal range 1..8).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid1  in  1  lane-1 instruction present
- rs1_addr1, rs2_addr1, rd_addr1  in  5 each  lane-1 source/destination register numbers
- wen1  in  1  lane-1 instruction writes rd_addr1
- valid2, rs1_addr2, rs2_addr2, rd_addr2, wen2  in  1/5/5/5/1  lane-2 equivalents
- issue1  out  1  lane 1 issues this cycle (combinational)
- issue2  out  1  lane 2 issues this cycle (combinational)
- wb_wen1, wb_wen2  out  1 each  register-file write enables, registered
- wb_rd1, wb_rd2  out  5 each  register-file write addresses, registered
- busy  out  32  scoreboard, bit n set = write to xn in flight
- stall_cnt  out  CNT_W  cycles lane 1 was valid but not issued

Behaviour:
- Reset (clk edge with rst=1): busy=0, both delay lines cleared, wb_wen1/2=0, wb_rd1/2=0, stall_cnt=0. Reset mid-flight discards all pending writes; no write-enable pulses after reset.
- x0 is never busy. A source or destination of 0 never causes a hazard. wen with rd=0 is treated as wen=0.
- Hazard checks use registered busy only; there is no bypass from a retiring write in the same cycle.
- issue1 = valid1 & !busy[rs1_addr1] & !busy[rs2_addr1] & !(wen1 & busy[rd_addr1]).
- issue2 = issue1 & valid2 & !busy[rs1_addr2] & !busy[rs2_addr2] & !(wen2 & busy[rd_addr2]) & !intra, where intra = wen1 & rd_addr1≠0 & (rs1_addr2==rd_addr1 | rs2_addr2==rd_addr1 | (wen2 & rd_addr2==rd_addr1)).
- Lane 2 never issues without lane 1; issue is in order.
- Issue of a writing instruction (rd≠0) sets busy[rd] at the next edge and enters (1, rd) into that lane's LAT-stage delay line. Non-writing issue enters (0, 0).
- The delay line output is registered onto wb_wen/wb_rd, so wb_wenN is high exactly LAT cycles after the issue cycle, for one cycle.
- In the cycle wb_wenN=1, busy[wb_rdN] clears at the next edge. An instruction dependent on it can issue one cycle after the write is visible on the port.
- Set and clear of the same bit on the same edge: set wins. The WAW stall makes this unreachable; it is stated for determinism.
- wb_wen1 and wb_wen2 may be high together; their rd differs by construction.
- stall_cnt increments when valid1 & !issue1, and saturates at all-ones.
- Inputs are sampled regardless of issue. The decode stage holds its inputs stable while not issued.

Test Plan:
- Reset then independent pair: lane1 rd=5 (rs 1,2), lane2 rd=6 (rs 3,4), LAT=3. Required: issue1=issue2=1; busy[5], busy[6] set next cycle; wb_wen1/wb_wen2 high 3 cycles later with wb_rd=5/6; busy clears the following cycle.
- Intra-pair RAW: lane1 rd=7, lane2 rs1=7. Required: issue1=1, issue2=0. Next cycle, with lane2 re-presented in lane1 position, issue1=0 until busy[7] clears; stall_cnt counts those cycles (3 for LAT=3).
- WAW against busy: x9 in flight, new lane1 wen rd=9. Required: issue1=0 until the cycle after wb_wen with wb_rd=9, then issue1=1.
- x0 handling: lane1 wen rd=0, lane2 rs1=0 and rd=0. Required: both issue, busy stays 0, wb_wen stays 0.
- Reset mid-operation: issue rd=12, assert rst 1 cycle later. Required: busy=0, no wb_wen pulse for x12 ever appears.
- Saturation with CNT_W=4: hold lane1 stalled 20 cycles. Required: stall_cnt=15 and holding.
